// File: rtl/lfsr_prng_pkg.sv
// rtl/lfsr_prng_pkg.sv - lfsr_pkg: mode constants, maximal-length taps, single-step function.
package lfsr_pkg;

  localparam int LFSR_FIBONACCI = 0;
  localparam int LFSR_GALOIS    = 1;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // One left shift of a width-bit LFSR held in the low bits of a 64-bit word.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s, input logic [63:0] taps,
                                            input int unsigned width, input int mode);
    logic [63:0] mask;
    logic [63:0] sh;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sh   = (s << 1) & mask;
    if (mode == LFSR_GALOIS)
      lfsr_next = sh ^ (s[6'(width - 1)] ? (taps & mask) : 64'd0);
    else
      lfsr_next = sh | {63'd0, ^(s & taps & mask)};
  endfunction

endpackage

// File: rtl/lfsr_prng_if.sv
// rtl/lfsr_prng_if.sv - lfsr_prng handshake/seed bundle; period outputs exist with LFSR_PERIOD_CNT_EN.
interface lfsr_prng_if #(parameter int WIDTH = 16);

  logic             en;
  logic             load_valid;
  logic [WIDTH-1:0] load_seed;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             lockup_err;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] period_len;
  logic             period_done;

  modport master (output en, load_valid, load_seed, out_ready,
                  input  out_valid, out_data, lockup_err, period_len, period_done);
  modport slave  (input  en, load_valid, load_seed, out_ready,
                  output out_valid, out_data, lockup_err, period_len, period_done);
`else
  modport master (output en, load_valid, load_seed, out_ready,
                  input  out_valid, out_data, lockup_err);
  modport slave  (input  en, load_valid, load_seed, out_ready,
                  output out_valid, out_data, lockup_err);
`endif

endinterface

// File: rtl/lfsr_prng_step.sv
// rtl/lfsr_prng_step.sv - lfsr_step: combinational single LFSR step.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter int               MODE  = LFSR_FIBONACCI
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  assign state_o = WIDTH'(lfsr_next(64'(state_i), 64'(TAPS), WIDTH, MODE));

endmodule

// File: rtl/lfsr_prng.sv
// rtl/lfsr_prng.sv - parametrised LFSR source with valid/ready output and seed load.
// Optional period counter enabled by LFSR_PERIOD_CNT_EN.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hB400),
  parameter int               MODE         = LFSR_FIBONACCI,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic        clk,
  input  logic        reset,
  lfsr_prng_if.slave  bus
);

  logic [WIDTH-1:0]           state_q, state_d;
  logic                       valid_q;
  logic                       err_q, err_d;
  logic [STEP:0][WIDTH-1:0]   chain;
  logic                       advance;
  logic                       restart;

  assign chain[0] = state_q;
  for (genvar g = 0; g < STEP; g++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_step (
      .state_i (chain[g]),
      .state_o (chain[g+1])
    );
  end

  assign advance = valid_q & bus.out_ready & bus.en;
  // A load or a zero-state recovery replaces the state and swallows any advance.
  assign restart = bus.load_valid | (state_q == '0);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (bus.load_valid) begin
      if (bus.load_seed == '0) begin
        state_d = DEFAULT_SEED;
        err_d   = 1'b1;
      end else begin
        state_d = bus.load_seed;
      end
    end else if (state_q == '0) begin
      state_d = DEFAULT_SEED;
      err_d   = 1'b1;
    end else if (advance) begin
      state_d = chain[STEP];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DEFAULT_SEED;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b1;
      err_q   <= err_d;
    end
  end

  assign bus.out_data   = state_q;
  assign bus.out_valid  = valid_q;
  assign bus.lockup_err = err_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] plen_q, plen_d;
  logic             pdone_q, pdone_d;

  // ref_q remembers the word the current period started from.
  always_comb begin
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    plen_d  = plen_q;
    pdone_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
      ref_d = state_d;
    end else if (advance) begin
      if (chain[STEP] == ref_q) begin
        plen_d  = cnt_q + WIDTH'(1);
        pdone_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      ref_q   <= DEFAULT_SEED;
      plen_q  <= '0;
      pdone_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      plen_q  <= plen_d;
      pdone_q <= pdone_d;
    end
  end

  assign bus.period_len  = plen_q;
  assign bus.period_done = pdone_q;
`endif

endmodule
